shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Iterative unsigned multiplier for the mini-GPU execute lane. Each cycle it drives the lane's 64-bit left barrel shifter with the multiplicand and a bit index. It consumes the shifted partial product and accumulates it. The block sits directly downstream of the shifter, and its operand/result handshake connects to the lane's issue and writeback logic. It returns the low WIDTH bits of a×b after a data-dependent number of cycles.

## Interface
- WIDTH, 64, operand/product width; the shifter port is fixed at 64 bits/6-bit amount, so only 64 is legal
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands a/b present
- in_ready  output  1  block can accept operands (high only in IDLE)
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- shift_in  output  WIDTH  to shifter in0: latched multiplicand
- shift_amt  output  6  to shifter shift_amount: current bit index
- shift_result  input  WIDTH  from shifter lsl: shift_in << shift_amt, combinational same cycle
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  WIDTH  low WIDTH bits of a×b, unsigned

## Operation
- States: IDLE, RUN, DONE. Encoding is free; there is no unused-state lockup, and any illegal state goes to IDLE.
- Registers: a_reg, b_reg, idx (6 bits), acc (WIDTH).
- IDLE:
  - in_ready=1.
  - On in_valid at the edge: a_reg<=in_a, b_reg<=in_b, idx<=0, acc<=0, go to RUN.
- RUN:
  - in_ready=0; shift_in=a_reg; shift_amt=idx.
  - If b_reg[idx]=1: acc<=acc+shift_result, modulo 2^WIDTH with carry-out discarded. Otherwise acc holds.
  - last = (idx==63) or (b_reg>>(idx+1))==0. Implement this as a registered "remaining bits" mask, or b_reg shifted right each cycle; either is acceptable if observable behaviour matches.
  - On last: go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; product=acc, held stable.
  - On out_ready at the edge: go to IDLE.
  - in_valid is ignored (in_ready=0).
- Outside RUN: shift_in=a_reg and shift_amt=0. The shifter result is ignored.
- product is driven from acc in all states. It is only meaningful while out_valid=1.
- Reset (rst_n low at an edge, in any state including mid-RUN or DONE):
  - State goes to IDLE.
  - a_reg, b_reg, acc and idx go to 0.
  - The in-flight operation is discarded with no out_valid pulse.
- Reset values: in_ready=1, out_valid=0, product=0, shift_in=0, shift_amt=0.

## Timing
- k = max(1, msb_index(in_b)+1) RUN cycles per operation:
  - b=0 gives k=1.
  - b=1 gives k=1.
  - b=0x5 gives k=3.
  - b=2^63 gives k=64.
- Accept edge E0 → out_valid rises at edge Ek (k cycles later).
- out_valid stays high until the edge where out_ready=1.
- in_ready rises at the edge after the out_ready handshake. Minimum issue interval is k+2 cycles when out_ready is tied high.
- out_ready already high when DONE is entered: DONE lasts exactly 1 cycle; the product is still presented for that cycle.
- in_valid held high during RUN/DONE has no effect. The next operands are taken only in the first IDLE cycle.
- The shifter path is combinational within one cycle. shift_amt and shift_in come from registers only, with no combinational path from inputs to shifter.
- Overflow: bits at position ≥WIDTH are dropped, both by the shifter and by the adder.

## Test plan
- Reset mid-RUN: a=3, b=0xFF, assert rst_n=0 at RUN cycle 4 → next cycle IDLE, in_ready=1, out_valid=0, product=0, no product ever emitted.
- Basic: a=7, b=5, out_ready=1 → out_valid exactly 3 cycles after accept, product=35; shift_amt sequence 0,1,2.
- Zero/one: b=0 with a=0xDEAD → product=0 after 1 cycle; a=0xDEAD, b=1 → product=0xDEAD after 1 cycle.
- Full length and wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF → product=0x0000_0000_0000_0001 after 64 cycles. a=2, b=2^63 → product=0, 64 cycles.
- Backpressure: a=6, b=9, out_ready=0 for 10 cycles after out_valid → product=54 held stable and out_valid held. A new in_valid with a=1, b=1 during the stall is ignored. After out_ready=1, IDLE accepts the new operands.
- Back-to-back with random a/b (1000 ops, out_ready randomly toggled) → every product equals (a*b) mod 2^64, and each latency equals max(1, msb(b)+1).

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
// Iterative unsigned shift-and-add multiplier for the execute lane. Each RUN
// cycle the latched multiplicand is sent to the lane's 64-bit left barrel
// shifter together with the current multiplier bit index. The shifted
// partial product comes back in the same cycle and is accumulated when that
// multiplier bit is set. The low WIDTH bits of a*b are presented after
// max(1, msb(b)+1) RUN cycles.
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only while idle)
//   in_a, in_b          multiplicand, multiplier
//   shift_in/shift_amt  to shifter: latched multiplicand, bit index
//   shift_result        from shifter: shift_in << shift_amt (combinational)
//   out_valid/out_ready product handshake
//   product             low WIDTH bits of a*b, valid while out_valid
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 64  // fixed by the 64-bit shifter port
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] shift_in,
  output logic [5:0]       shift_amt,
  input  logic [WIDTH-1:0] shift_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  // Multiplier shifted right once per RUN cycle, so bit 0 is always the bit
  // at the current index and the upper bits are the ones still to process.
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [5:0]       idx_q, idx_d;
  logic             last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Stop once no set multiplier bits remain above the current index.
  assign last = (idx_q == 6'd63) || (b_q[WIDTH-1:1] == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (b_q[0]) begin
          acc_d = acc_q + shift_result;  // carry-out dropped
        end
        b_d = b_q >> 1;
        if (last) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = acc_q;
  assign shift_in  = a_q;
  assign shift_amt = (state_q == S_RUN) ? idx_q : 6'd0;

endmodule
